// File: rtl/dose_scheduler.sv
// Slot-table dose scheduler: RTC matches and manual edges queue per-compartment requests, served lowest-first
// as one solenoid pulse at a time (1 clock from pending to drive, then PULSE_CYCLES on, GAP_CYCLES off).
module dose_scheduler #(
    parameter int N_CHAN       = 3,
    parameter int N_SLOTS      = 4,
    parameter int PULSE_CYCLES = 50000000,
    parameter int GAP_CYCLES   = 5000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [5:0]                 seconds,
    input  logic [5:0]                 minutes,
    input  logic [4:0]                 hours,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SLOTS)-1:0] cfg_slot,
    input  logic [4:0]                 cfg_hour,
    input  logic [5:0]                 cfg_min,
    input  logic [N_CHAN-1:0]          cfg_mask,
    input  logic [N_CHAN-1:0]          manual_req,
    input  logic                       clr_missed,
    output logic [N_CHAN-1:0]          gpio_port,
    output logic [N_CHAN-1:0]          pending,
    output logic [N_CHAN-1:0]          missed,
    output logic                       busy
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    logic [4:0]        slot_hour_q [N_SLOTS];
    logic [5:0]        slot_min_q  [N_SLOTS];
    logic [N_CHAN-1:0] slot_mask_q [N_SLOTS];
    logic [N_SLOTS-1:0] time_eq, match_q;
    logic [N_CHAN-1:0] manual_q;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_CHAN-1:0] gpio_q, gpio_d;
    logic [N_CHAN-1:0] pending_q, pending_d;
    logic [N_CHAN-1:0] missed_q, missed_d;

    logic [N_CHAN-1:0] req, drop, sel_oh, consume;
    logic              serve;

    // The edge register tracks the time comparison alone, so rewriting a slot's mask or time while the
    // RTC already sits on that second cannot produce a late trigger.
    always_comb begin
        req = manual_req & ~manual_q;
        for (int s = 0; s < N_SLOTS; s++) begin
            time_eq[s] = (hours == slot_hour_q[s]) && (minutes == slot_min_q[s]) && (seconds == 6'd0);
            if (time_eq[s] && !match_q[s]) begin
                req = req | slot_mask_q[s];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                slot_hour_q[s] <= '0;
                slot_min_q[s]  <= '0;
                slot_mask_q[s] <= '0;
            end
            match_q  <= '0;
            manual_q <= '0;
        end else begin
            match_q  <= time_eq;
            manual_q <= manual_req;
            if (cfg_we) begin
                slot_hour_q[cfg_slot] <= cfg_hour;
                slot_min_q[cfg_slot]  <= cfg_min;
                slot_mask_q[cfg_slot] <= cfg_mask;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gpio_q    <= '0;
            pending_q <= '0;
            missed_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gpio_q    <= gpio_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|pending_q) state_d = S_PULSE;
            S_PULSE: if (cnt_q == '0) state_d = S_GAP;
            S_GAP:   if (cnt_q == '0) state_d = (|pending_q) ? S_PULSE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A gap that expires with work queued starts the next pulse directly, keeping the off-time exact.
    always_comb begin
        sel_oh  = pending_q & (~pending_q + N_CHAN'(1));
        serve   = (|pending_q) && ((state_q == S_IDLE) || ((state_q == S_GAP) && (cnt_q == '0)));
        consume = serve ? sel_oh : '0;
        cnt_d   = cnt_q;
        gpio_d  = gpio_q;
        case (state_q)
            S_PULSE: begin
                if (cnt_q == '0) begin
                    gpio_d = '0;
                    cnt_d  = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP:   if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (serve) begin
            gpio_d = sel_oh;
            cnt_d  = PULSE_LD;
        end
        drop      = req & pending_q & ~consume;
        pending_d = (pending_q & ~consume) | req;
        missed_d  = (clr_missed ? '0 : missed_q) | drop;
    end

    assign gpio_port = gpio_q;
    assign pending   = pending_q;
    assign missed    = missed_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: directed scenarios plus random traffic against a time-arithmetic reference model.
module tb_dose_scheduler;
    localparam int NC = 3;
    localparam int NS = 4;
    localparam int P  = 4;
    localparam int G  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds = '0, minutes = '0;
    logic [4:0] hours = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_slot = '0;
    logic [4:0] cfg_hour = '0;
    logic [5:0] cfg_min = '0;
    logic [2:0] cfg_mask = '0;
    logic [2:0] manual_req = '0;
    logic       clr_missed = 1'b0;
    logic [2:0] gpio_port, pending, missed;
    logic       busy;

    dose_scheduler #(.N_CHAN(NC), .N_SLOTS(NS), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour(cfg_hour), .cfg_min(cfg_min),
        .cfg_mask(cfg_mask), .manual_req(manual_req), .clr_missed(clr_missed),
        .gpio_port(gpio_port), .pending(pending), .missed(missed), .busy(busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int ecount = 0;
    int pulses_seen = 0;
    bit chk_en = 1'b0;

    // Reference model: a slot table, per-slot "already seen this second" flags, and a server that is free
    // again P+G edges after it starts a pulse.
    logic [4:0] m_hour [NS];
    logic [5:0] m_min  [NS];
    logic [2:0] m_mask [NS];
    bit         m_prev_eq [NS];
    logic [2:0] m_man = '0, m_pending = '0, m_missed = '0, m_gpio = '0;
    int         m_free = 0, m_end = 0, m_ch = 0;
    bit         m_busy = 1'b0;

    typedef struct { int ch; int start; } pulse_t;
    pulse_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    function automatic void model_edge(input int n);
        logic [2:0] req, consumed, drop;
        bit eq;
        int lo;
        pulse_t pe;
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                m_hour[s] = '0; m_min[s] = '0; m_mask[s] = '0; m_prev_eq[s] = 1'b0;
            end
            m_man = '0; m_pending = '0; m_missed = '0; m_gpio = '0;
            m_free = 0; m_end = 0;
            sbq.delete();
        end else begin
            req = manual_req & ~m_man;
            m_man = manual_req;
            for (int s = 0; s < NS; s++) begin
                eq = (hours == m_hour[s]) && (minutes == m_min[s]) && (seconds == 0);
                if (eq && !m_prev_eq[s]) req = req | m_mask[s];
                m_prev_eq[s] = eq;
            end
            if (cfg_we) begin
                m_hour[cfg_slot] = cfg_hour; m_min[cfg_slot] = cfg_min; m_mask[cfg_slot] = cfg_mask;
            end
            consumed = '0;
            if (m_pending != 0 && n >= m_free) begin
                lo = 0;
                for (int c = NC - 1; c >= 0; c--) if (m_pending[c]) lo = c;
                m_ch = lo; m_end = n + P; m_free = n + P + G;
                consumed = 3'(1 << lo);
                pe.ch = lo; pe.start = n;
                sbq.push_back(pe);
            end
            m_gpio = (n < m_end) ? 3'(1 << m_ch) : 3'b000;
            drop = req & m_pending & ~consumed;
            m_pending = (m_pending & ~consumed) | req;
            m_missed = (clr_missed ? 3'b000 : m_missed) | drop;
        end
        m_busy = (n < m_free);
    endfunction

    task automatic tick();
        @(posedge clock);
        ecount++;
        model_edge(ecount);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic cfg(input int slot, input int h, input int m, input int mask);
        cfg_we = 1'b1; cfg_slot = 2'(slot); cfg_hour = 5'(h); cfg_min = 6'(m); cfg_mask = 3'(mask);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
    endtask

    // Monitor: per-cycle comparison against the model, and scoreboard pop on each new pulse.
    logic [2:0] prev_gpio = '0;
    always @(negedge clock) begin : monitor
        pulse_t e;
        if (chk_en) begin
            check("gpio", gpio_port, m_gpio);
            check("pending", pending, m_pending);
            check("missed", missed, m_missed);
            check("busy", busy, m_busy);
            check("onehot0", $onehot0(gpio_port), 1);
            if (gpio_port != 0 && prev_gpio == 0) begin
                pulses_seen++;
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pulse_unexpected: got %0h expected none (edge %0d)", gpio_port, ecount);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_chan", gpio_port, 1 << e.ch);
                    check("pulse_start", ecount, e.start);
                end
            end
            prev_gpio = gpio_port;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    int th[4] = '{6, 12, 18, 23};
    int tm[4] = '{30, 0, 45, 59};

    initial begin : stim
        int base, r, k;
        reset = 1'b1;
        repeat (2) tick();
        check("rst_gpio", gpio_port, 0);
        check("rst_pending", pending, 0);
        check("rst_missed", missed, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // 1: single slot fires once while the RTC holds 08:00:00
        cfg(0, 8, 0, 1);
        set_time(7, 59, 59); tick();
        base = pulses_seen;
        set_time(8, 0, 0); tick();
        check("s1_pending", pending, 3'b001);
        check("s1_gpio_early", gpio_port, 3'b000);
        tick();
        check("s1_gpio", gpio_port, 3'b001);
        repeat (18) tick();
        set_time(8, 0, 1); repeat (5) tick();
        check("s1_pulses", pulses_seen - base, 1);

        // 2: two slots at one time merge into three served pulses
        cfg(1, 13, 0, 5); cfg(2, 13, 0, 2);
        base = pulses_seen;
        set_time(13, 0, 0); repeat (25) tick();
        set_time(13, 0, 1); tick();
        check("s2_pulses", pulses_seen - base, 3);

        // 3: repeated manual request while still pending is dropped and flagged
        manual_req = 3'b001; tick(); manual_req = 3'b000; tick();
        manual_req = 3'b010; tick(); manual_req = 3'b000; tick();
        manual_req = 3'b010; tick(); manual_req = 3'b000;
        check("s3_missed", missed, 3'b010);
        repeat (15) tick();
        clr_missed = 1'b1; tick(); clr_missed = 1'b0;
        check("s3_clr", missed, 3'b000);

        // 4: new request on the consume edge keeps pending set
        base = pulses_seen;
        set_time(8, 0, 0); tick();
        manual_req = 3'b001; tick();
        check("s4_pending", pending, 3'b001);
        check("s4_gpio", gpio_port, 3'b001);
        manual_req = 3'b000; set_time(8, 0, 1);
        repeat (20) tick();
        check("s4_pulses", pulses_seen - base, 2);

        // 5: reset mid-pulse wipes queue and table
        set_time(13, 0, 1); tick();
        set_time(13, 0, 0); tick(); tick();
        check("s5_pending_pre", pending, 3'b110);
        check("s5_gpio_pre", gpio_port, 3'b001);
        reset = 1'b1; tick(); reset = 1'b0;
        check("s5_gpio", gpio_port, 3'b000);
        check("s5_pending", pending, 3'b000);
        check("s5_busy", busy, 0);
        base = pulses_seen;
        set_time(8, 0, 1); tick();
        set_time(8, 0, 0); repeat (10) tick();
        check("s5_pulses", pulses_seen - base, 0);

        // 6: disabled slot, then an enable written on the first matching edge
        cfg(3, 20, 0, 0);
        base = pulses_seen;
        set_time(20, 0, 0); repeat (10) tick();
        set_time(19, 59, 59); tick();
        cfg_we = 1'b1; cfg_slot = 2'd3; cfg_hour = 5'd20; cfg_min = 6'd0; cfg_mask = 3'b100;
        set_time(20, 0, 0); tick(); cfg_we = 1'b0;
        repeat (10) tick();
        check("s6_pulses", pulses_seen - base, 0);
        set_time(20, 0, 1); tick();

        // random traffic
        for (int s = 0; s < NS; s++) cfg(s, th[s], tm[s], int'($urandom_range(0, 7)));
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            k = int'($urandom_range(0, 3));
            if (r < 3)       set_time(th[k], tm[k], 0);
            else if (r < 6)  seconds = 6'd1;
            else if (r < 8)  hours = 5'($urandom_range(24, 31));
            if ($urandom_range(0, 4) == 0) manual_req = 3'($urandom_range(0, 7));
            cfg_we = ($urandom_range(0, 49) == 0);
            cfg_slot = 2'($urandom_range(0, 3));
            cfg_hour = 5'(th[k]); cfg_min = 6'(tm[k]); cfg_mask = 3'($urandom_range(0, 7));
            clr_missed = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; cfg_we = 1'b0; clr_missed = 1'b0; manual_req = '0; seconds = 6'd1;
        repeat (40) tick();
        check("drain_queue", sbq.size(), 0);
        check("drain_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
